// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: register-file-wide constants shared by the write-back queue,
// its bypass matcher and the regfile itself.
//   REG_ADDR_W / REG_DATA_W : register address and data widths
//   REG_ZERO                : hard-wired zero register, never written
//   WBQ_DEPTH               : default write-back queue depth (power of 2, >=2)
package wb_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int WBQ_DEPTH = 4;

endpackage

// File: rtl/wb_queue_if.sv
// wb_queue_if: bundle of every non-clock signal of the write-back queue.
//   producer A/B  : a_valid/a_ready/a_reg/a_data, b_valid/b_ready/b_reg/b_data
//   regfile write : regwrite/wreg/wdata (registered)
//   bypass lookup : rreg1/rreg2 keys, fwd1_hit/fwd1_data, fwd2_hit/fwd2_data
//   status        : count (occupied entries)
// slave = the queue, master = producers/decode/regfile side.
interface wb_queue_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 3
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;
    logic              regwrite;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] rreg1;
    logic [ADDR_W-1:0] rreg2;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd2_data;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, rreg1, rreg2,
        output a_ready, b_ready, regwrite, wreg, wdata,
        output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
    );

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data, rreg1, rreg2,
        input  a_ready, b_ready, regwrite, wreg, wdata,
        input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count
    );
endinterface

// File: rtl/wb_queue_match.sv
// wb_match: combinational youngest-first lookup over the pending write-backs.
//   ent_reg/ent_data/ent_valid : queue storage, head : oldest slot, count : occupancy
//   out_valid/out_reg/out_data : write already presented to the regfile (oldest of all)
//   key                        : register being read
//   hit/data                   : youngest pending value for key; never hits on the zero register
module wb_match
    import wb_queue_pkg::*;
#(
    parameter int DEPTH  = WBQ_DEPTH,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] ent_reg,
    input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
    input  logic [DEPTH-1:0]             ent_valid,
    input  logic [PTR_W-1:0]             head,
    input  logic [CNT_W-1:0]             count,
    input  logic                         out_valid,
    input  logic [ADDR_W-1:0]            out_reg,
    input  logic [DATA_W-1:0]            out_data,
    input  logic [ADDR_W-1:0]            key,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    logic              hit_s;
    logic [DATA_W-1:0] data_s;
    logic [PTR_W-1:0]  idx_s;
    logic              m_s;

    // Walk oldest to youngest so the last match (the youngest) overrides earlier ones.
    always_comb begin
        hit_s  = out_valid && (out_reg == key);
        data_s = hit_s ? out_data : {DATA_W{1'b0}};
        idx_s  = head;
        m_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s  = head + PTR_W'(i);
            m_s    = (CNT_W'(i) < count) && ent_valid[idx_s] && (ent_reg[idx_s] == key);
            hit_s  = hit_s | m_s;
            data_s = m_s ? ent_data[idx_s] : data_s;
        end
        hit  = hit_s && (key != ADDR_W'(REG_ZERO));
        data = hit ? data_s : {DATA_W{1'b0}};
    end

endmodule

// File: rtl/wb_queue.sv
// wb_queue: in-order write-back queue feeding the regfile's single write port.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : wb_queue_if.slave -- producers A/B (A is older when both push),
//           registered regfile write port, two bypass lookups, occupancy count.
// Writes to the zero register complete the handshake but are dropped.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int DEPTH  = WBQ_DEPTH,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic        clk,
    input  logic        reset,
    wb_queue_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] ent_reg_r;
    logic [DEPTH-1:0][DATA_W-1:0] ent_data_r;
    logic [DEPTH-1:0]             ent_valid_r;
    logic [PTR_W-1:0]             head_r;
    logic [PTR_W-1:0]             tail_r;
    logic [CNT_W-1:0]             count_r;
    logic                         regwrite_r;
    logic [ADDR_W-1:0]            wreg_r;
    logic [DATA_W-1:0]            wdata_r;

    logic              a_ready_s;
    logic              b_ready_s;
    logic              push_a_s;
    logic              push_b_s;
    logic              pop_s;
    logic [PTR_W-1:0]  tail_b_s;
    logic [CNT_W-1:0]  count_next_s;

    // Ready uses occupancy before this cycle's pop, so a full queue never accepts even while draining.
    always_comb begin
        a_ready_s = (count_r < DEPTH_C);
        if (bus.a_valid) begin
            b_ready_s = (count_r <= (DEPTH_C - CNT_W'(2)));
        end else begin
            b_ready_s = (count_r < DEPTH_C);
        end
        push_a_s     = bus.a_valid && a_ready_s && (bus.a_reg != ADDR_W'(REG_ZERO));
        push_b_s     = bus.b_valid && b_ready_s && (bus.b_reg != ADDR_W'(REG_ZERO));
        pop_s        = (count_r != {CNT_W{1'b0}});
        tail_b_s     = push_a_s ? (tail_r + PTR_W'(1)) : tail_r;
        count_next_s = count_r + CNT_W'(push_a_s) + CNT_W'(push_b_s) - CNT_W'(pop_s);
    end

    // Queue storage, pointers, occupancy and the registered regfile write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_reg_r   <= '{default: {ADDR_W{1'b0}}};
            ent_data_r  <= '{default: {DATA_W{1'b0}}};
            ent_valid_r <= {DEPTH{1'b0}};
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            regwrite_r  <= 1'b0;
            wreg_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {DATA_W{1'b0}};
        end else begin
            if (pop_s) begin
                ent_valid_r[head_r] <= 1'b0;
                head_r              <= head_r + PTR_W'(1);
                regwrite_r          <= 1'b1;
                wreg_r              <= ent_reg_r[head_r];
                wdata_r             <= ent_data_r[head_r];
            end else begin
                regwrite_r          <= 1'b0;
            end
            if (push_a_s) begin
                ent_reg_r[tail_r]   <= bus.a_reg;
                ent_data_r[tail_r]  <= bus.a_data;
                ent_valid_r[tail_r] <= 1'b1;
            end
            if (push_b_s) begin
                ent_reg_r[tail_b_s]   <= bus.b_reg;
                ent_data_r[tail_b_s]  <= bus.b_data;
                ent_valid_r[tail_b_s] <= 1'b1;
            end
            tail_r  <= tail_b_s + PTR_W'(push_b_s);
            count_r <= count_next_s;
        end
    end

    wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match1 (
        .ent_reg(ent_reg_r), .ent_data(ent_data_r), .ent_valid(ent_valid_r),
        .head(head_r), .count(count_r),
        .out_valid(regwrite_r), .out_reg(wreg_r), .out_data(wdata_r),
        .key(bus.rreg1), .hit(bus.fwd1_hit), .data(bus.fwd1_data)
    );

    wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match2 (
        .ent_reg(ent_reg_r), .ent_data(ent_data_r), .ent_valid(ent_valid_r),
        .head(head_r), .count(count_r),
        .out_valid(regwrite_r), .out_reg(wreg_r), .out_data(wdata_r),
        .key(bus.rreg2), .hit(bus.fwd2_hit), .data(bus.fwd2_data)
    );

    assign bus.a_ready  = a_ready_s;
    assign bus.b_ready  = b_ready_s;
    assign bus.regwrite = regwrite_r;
    assign bus.wreg     = wreg_r;
    assign bus.wdata    = wdata_r;
    assign bus.count    = count_r;

endmodule
